// File: rtl/lemmings_dig_scheduler.sv
// Round-robin owner of the single dig permit: pulses dig, times the dig, opens a hole on timeout.
// dig follows an IDLE sample by one cycle; requests are only sampled in IDLE, nothing is stalled upstream.
module lemmings_dig_scheduler #(
    parameter int N           = 4,
    parameter int MAX_DIG     = 16,
    parameter int ACK_TIMEOUT = 4,
    parameter int COOLDOWN    = 2
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic [N-1:0]         dig_req,
    input  logic [N-1:0]         lem_digging,
    output logic [N-1:0]         dig,
    output logic [N-1:0]         hole,
    output logic                 busy,
    output logic [$clog2(N)-1:0] owner,
    output logic                 denied
);

    localparam int OW   = $clog2(N);
    localparam int M1   = (MAX_DIG > ACK_TIMEOUT) ? MAX_DIG : ACK_TIMEOUT;
    localparam int CMAX = (M1 > COOLDOWN) ? M1 : COOLDOWN;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GRANT   = 3'd1,
        ACK     = 3'd2,
        DIG     = 3'd3,
        RELEASE = 3'd4,
        COOL    = 3'd5
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [OW-1:0] owner_nxt;
    logic [OW-1:0] last_owner, last_owner_nxt;
    logic          denied_nxt;

    logic [N-1:0]  upper_mask;
    logic [N-1:0]  req_hi;
    logic [N-1:0]  pick_src;
    logic [OW-1:0] pick_idx;

    // Requests above the previous owner win; otherwise wrap to the lowest requester.
    always_comb begin
        upper_mask = '0;
        for (int i = 0; i < N; i++) begin
            upper_mask[i] = (i > int'(last_owner));
        end
        req_hi   = dig_req & upper_mask;
        pick_src = (req_hi != '0) ? req_hi : dig_req;
        pick_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pick_src[i]) begin
                pick_idx = OW'(i);
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        owner_nxt      = owner;
        last_owner_nxt = last_owner;
        denied_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (dig_req != '0) begin
                    owner_nxt = pick_idx;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                state_nxt = ACK;
                cnt_nxt   = '0;
            end
            ACK: begin
                if (lem_digging[owner]) begin
                    state_nxt = DIG;
                    cnt_nxt   = '0;
                end else if (int'(cnt) + 1 >= ACK_TIMEOUT - 1) begin
                    denied_nxt     = 1'b1;
                    state_nxt      = COOL;
                    cnt_nxt        = '0;
                    last_owner_nxt = owner;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            DIG: begin
                if (!lem_digging[owner]) begin
                    state_nxt      = COOL;
                    cnt_nxt        = '0;
                    last_owner_nxt = owner;
                end else if (cnt == CW'(MAX_DIG - 1)) begin
                    state_nxt = RELEASE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            RELEASE: begin
                if (!lem_digging[owner]) begin
                    state_nxt      = COOL;
                    cnt_nxt        = '0;
                    last_owner_nxt = owner;
                end
            end
            COOL: begin
                if (cnt == CW'(COOLDOWN - 1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state      <= IDLE;
            cnt        <= '0;
            owner      <= '0;
            last_owner <= OW'(N - 1);
            denied     <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            owner      <= owner_nxt;
            last_owner <= last_owner_nxt;
            denied     <= denied_nxt;
        end
    end

    // Decoded from state so that reset drops dig and hole without waiting for an edge.
    assign busy = (state != IDLE);
    assign dig  = (state == GRANT)   ? (ONE << owner) : '0;
    assign hole = (state == RELEASE) ? (ONE << owner) : '0;

endmodule

// File: tb/tb_lemmings_dig_scheduler.sv
// Randomized bench for lemmings_dig_scheduler: the bench plays level controller and lemming array,
// and predicts each ownership's timeline from the round-robin and timing rules.
module tb_lemmings_dig_scheduler;

    localparam int N           = 4;
    localparam int MAX_DIG     = 16;
    localparam int ACK_TIMEOUT = 4;
    localparam int COOLDOWN    = 2;

    logic         clk = 1'b0;
    logic         areset;
    logic [N-1:0] dig_req;
    logic [N-1:0] lem_digging;
    logic [N-1:0] dig;
    logic [N-1:0] hole;
    logic         busy;
    logic [1:0]   owner;
    logic         denied;

    int checks = 0;
    int errors = 0;
    int model_last = N - 1;
    int model_own  = 0;

    lemmings_dig_scheduler #(
        .N(N), .MAX_DIG(MAX_DIG), .ACK_TIMEOUT(ACK_TIMEOUT), .COOLDOWN(COOLDOWN)
    ) dut (
        .clk(clk), .areset(areset), .dig_req(dig_req), .lem_digging(lem_digging),
        .dig(dig), .hole(hole), .busy(busy), .owner(owner), .denied(denied)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] m, input int last);
        for (int i = 1; i <= N; i++) begin
            if (m[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    // Called just after a negedge; returns just after a later negedge with the DUT idle.
    task automatic do_reset();
        #1 areset = 1'b1;
        #1;
        chk("rst_dig", dig, 0);
        chk("rst_hole", hole, 0);
        chk("rst_busy", busy, 0);
        chk("rst_denied", denied, 0);
        chk("rst_owner", owner, 0);
        dig_req     = '0;
        lem_digging = '0;
        @(negedge clk);
        areset     = 1'b0;
        model_last = N - 1;
        model_own  = 0;
    endtask

    task automatic idle_cycles(input int n);
        dig_req = '0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            chk("idle_busy", busy, 0);
            chk("idle_dig", dig, 0);
            chk("idle_hole", hole, 0);
            chk("idle_owner", owner, model_own);
        end
    endtask

    // kind 0: acks at cycle a, clears h cycles into the hole; kind 1: never acks;
    // kind 2: acks at cycle a, falls after p DIG cycles. Cycle 0 is the dig pulse.
    // mode 0 holds req, 1 scrambles it, 2 drops it and re-raises it during COOL.
    task automatic run_txn(input logic [N-1:0] req, input int kind, input int a, input int p,
                           input int mode, input int rst_at);
        int exp_own, idle_t, denied_t, hole_lo, hole_hi, act_lo, act_hi, rel;
        logic [N-1:0] oh, lem;
        exp_own  = rr_pick(req, model_last);
        oh       = '0;
        oh[exp_own] = 1'b1;
        denied_t = -1;
        hole_lo  = -1;
        hole_hi  = -2;
        act_lo   = -1;
        act_hi   = -1;
        idle_t   = 0;
        case (kind)
            0: begin
                rel     = a + MAX_DIG + 1;
                act_lo  = a;
                act_hi  = rel + p;
                hole_lo = rel;
                hole_hi = rel + p;
                idle_t  = rel + p + 1 + COOLDOWN;
            end
            1: begin
                denied_t = ACK_TIMEOUT;
                idle_t   = ACK_TIMEOUT + COOLDOWN;
            end
            default: begin
                act_lo = a;
                act_hi = a + 1 + p;
                idle_t = a + 2 + p + COOLDOWN;
            end
        endcase
        dig_req = req;
        for (int t = 0; t <= idle_t; t++) begin
            @(negedge clk);
            if (t == rst_at) begin
                do_reset();
                return;
            end
            chk("dig", dig, (t == 0) ? oh : 0);
            chk("hole", hole, (t >= hole_lo && t <= hole_hi) ? oh : 0);
            chk("busy", busy, t < idle_t);
            chk("denied", denied, t == denied_t);
            chk("owner", owner, exp_own);
            lem = N'($urandom) & ~oh;
            if (t >= act_lo && t < act_hi) lem = lem | oh;
            lem_digging = lem;
            if (t < idle_t) begin
                if (mode == 1) dig_req = N'($urandom);
                else if (mode == 2) dig_req = (t >= idle_t - COOLDOWN) ? req : '0;
            end
        end
        model_last = exp_own;
        model_own  = exp_own;
    endtask

    initial begin
        int kind, a, p, mode, rst_at;
        logic [N-1:0] req;
        areset      = 1'b1;
        dig_req     = '0;
        lem_digging = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_dig", dig, 0);
        chk("reset_hole", hole, 0);
        chk("reset_denied", denied, 0);
        chk("reset_owner", owner, 0);
        areset = 1'b0;
        idle_cycles(2);

        // Reset while digging with cnt=5, then a fresh request for lemming 0.
        run_txn(4'b0001, 0, 1, 2, 0, 1 + 1 + 5);
        run_txn(4'b0001, 0, 1, 2, 0, -1);
        chk("regrant_after_reset", owner, 0);
        idle_cycles(1);

        do_reset();
        for (int g = 0; g < 5; g++) begin
            run_txn(4'b1111, 0, $urandom_range(1, ACK_TIMEOUT - 1), $urandom_range(0, 3), 0, -1);
            chk("rr_order", owner, g % N);
        end

        run_txn(4'b0100, 1, 1, 0, 0, -1);
        chk("denied_owner", owner, 2);
        run_txn(4'b0100, 2, 1, 7, 0, -1);
        run_txn(4'b1100, 0, 2, 1, 0, -1);
        chk("next_after_fall", owner, 3);

        run_txn(4'b0010, 0, 1, 0, 2, -1);
        run_txn(4'b0010, 0, 3, 3, 0, -1);
        chk("single_regrant", owner, 1);

        // Reset while the hole is open.
        run_txn(4'b1000, 0, 1, 3, 0, 1 + MAX_DIG + 2);
        idle_cycles(1);

        for (int r = 0; r < 40; r++) begin
            req    = N'($urandom_range(1, (1 << N) - 1));
            kind   = $urandom_range(0, 2);
            a      = $urandom_range(1, ACK_TIMEOUT - 1);
            p      = (kind == 0) ? $urandom_range(0, 3) : $urandom_range(0, MAX_DIG - 1);
            mode   = $urandom_range(0, 2);
            rst_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, ACK_TIMEOUT + COOLDOWN - 1) : -1;
            run_txn(req, kind, a, p, mode, rst_at);
            idle_cycles($urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
